// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two CPU requesters (fetch and MEM stage), the
// arbiter and the shared memory bus slave.
//   master : arbiter view (takes requests, drives the bus command, acks,
//            read data, bus_err_o and stallreq_o)
//   slave  : environment view (requesters plus bus slave), opposite directions
interface mem_bus_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;

  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  logic        stallreq_o;

  modport master (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_ack_o,
    output bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i,
    output bus_err_o, stallreq_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_ack_o,
    input  bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i,
    input  bus_err_o, stallreq_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single memory bus. The MEM stage (older
// instruction) has fixed priority over instruction fetch. One access is in
// flight at a time; it ends on bus_ack_i or is aborted after TIMEOUT busy
// cycles without an ack (owner gets ack with zero data plus bus_err_o).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_bus_arbiter_if.master (requesters, bus command, status)
// Parameter:
//   TIMEOUT  : busy cycles without bus_ack_i before abort (2..31)
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.master   bus
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  bus_cmd_t    cmd_q, cmd_d;
  logic        stb_q, stb_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic        err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  // A requester still holds req during its own ack cycle; masking it there
  // keeps the same request from being issued twice.
  logic mem_win, if_win;
  assign mem_win = bus.mem_req_i & ~mem_ack_q;
  assign if_win  = bus.if_req_i  & ~if_ack_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    stb_d       = stb_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_win) begin
          state_d     = MEM_BUSY;
          stb_d       = 1'b1;
          cnt_d       = '0;
          cmd_d.we    = bus.mem_we_i;
          cmd_d.sel   = bus.mem_sel_i;
          cmd_d.addr  = bus.mem_addr_i;
          cmd_d.wdata = bus.mem_wdata_i;
        end else if (if_win) begin
          state_d     = IF_BUSY;
          stb_d       = 1'b1;
          cnt_d       = '0;
          cmd_d.we    = 1'b0;
          cmd_d.sel   = 4'b1111;
          cmd_d.addr  = bus.if_addr_i;
          cmd_d.wdata = '0;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (bus.bus_ack_i) begin
          state_d = IDLE;
          stb_d   = 1'b0;
          if (state_q == IF_BUSY) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.bus_rdata_i;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = cmd_q.we ? 32'h0 : bus.bus_rdata_i;
          end
        end else if (cnt_q == CNT_LAST) begin
          // TIMEOUT-th busy cycle with no ack: abort
          state_d = IDLE;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          if (state_q == IF_BUSY) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      stb_q       <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      stb_q       <= stb_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.bus_stb_o   = stb_q;
  assign bus.bus_we_o    = cmd_q.we;
  assign bus.bus_sel_o   = cmd_q.sel;
  assign bus.bus_addr_o  = cmd_q.addr;
  assign bus.bus_wdata_o = cmd_q.wdata;
  assign bus.bus_err_o   = err_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.mem_ack_o   = mem_ack_q;
  assign bus.mem_rdata_o = mem_rdata_q;

  assign bus.stallreq_o = (bus.mem_req_i & ~mem_ack_q) | (bus.if_req_i & ~if_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int TIMEOUT = 16;
  localparam int NONE = 0, FETCH = 1, DATA = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bif();
  mem_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bif));

  int n_chk = 0;
  int n_fail = 0;
  int stb_rises = 0;
  logic prev_stb = 1'b0;

  // transaction-level reference: who owns the bus, how long it has waited,
  // and the externally visible results
  int          m_own = NONE;
  int          m_busy_cycles = 0;
  bit          m_stb, m_we, m_if_ack, m_mem_ack, m_err;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_mem_rd;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic finish_access(logic [31:0] data, bit timed_out);
    m_stb = 0;
    m_err = timed_out;
    if (m_own == FETCH) begin
      m_if_ack = 1;
      m_if_rd  = timed_out ? 32'h0 : data;
    end else begin
      m_mem_ack = 1;
      m_mem_rd  = (timed_out || m_we) ? 32'h0 : data;
    end
    m_own = NONE;
  endtask

  // advance the reference by one rising edge using the inputs now applied
  task automatic model_edge();
    bit had_if_ack, had_mem_ack;
    had_if_ack  = m_if_ack;
    had_mem_ack = m_mem_ack;
    if (rst) begin
      m_own = NONE; m_busy_cycles = 0;
      m_stb = 0; m_we = 0; m_sel = 0; m_addr = 0; m_wdata = 0;
      m_if_ack = 0; m_mem_ack = 0; m_err = 0; m_if_rd = 0; m_mem_rd = 0;
      return;
    end
    m_if_ack = 0; m_mem_ack = 0; m_err = 0;
    if (m_own == NONE) begin
      if (bif.mem_req_i && !had_mem_ack) begin
        m_own = DATA; m_busy_cycles = 0; m_stb = 1;
        m_we = bif.mem_we_i; m_sel = bif.mem_sel_i;
        m_addr = bif.mem_addr_i; m_wdata = bif.mem_wdata_i;
      end else if (bif.if_req_i && !had_if_ack) begin
        m_own = FETCH; m_busy_cycles = 0; m_stb = 1;
        m_we = 0; m_sel = 4'hF; m_addr = bif.if_addr_i; m_wdata = 0;
      end
    end else begin
      m_busy_cycles++;
      if (bif.bus_ack_i) finish_access(bif.bus_rdata_i, 0);
      else if (m_busy_cycles == TIMEOUT) finish_access(32'h0, 1);
    end
  endtask

  task automatic check_all(string tag);
    bit exp_stall;
    exp_stall = (bif.mem_req_i && !m_mem_ack) || (bif.if_req_i && !m_if_ack);
    chk({tag, ".stb"},       bif.bus_stb_o,   m_stb);
    chk({tag, ".we"},        bif.bus_we_o,    m_we);
    chk({tag, ".sel"},       bif.bus_sel_o,   m_sel);
    chk({tag, ".addr"},      bif.bus_addr_o,  m_addr);
    chk({tag, ".wdata"},     bif.bus_wdata_o, m_wdata);
    chk({tag, ".if_ack"},    bif.if_ack_o,    m_if_ack);
    chk({tag, ".mem_ack"},   bif.mem_ack_o,   m_mem_ack);
    chk({tag, ".err"},       bif.bus_err_o,   m_err);
    chk({tag, ".if_rdata"},  bif.if_rdata_o,  m_if_rd);
    chk({tag, ".mem_rdata"}, bif.mem_rdata_o, m_mem_rd);
    chk({tag, ".stallreq"},  bif.stallreq_o,  exp_stall);
  endtask

  task automatic tick(string tag);
    model_edge();
    @(posedge clk);
    #1;
    if (!prev_stb && bif.bus_stb_o === 1'b1) stb_rises++;
    prev_stb = bif.bus_stb_o;
    check_all(tag);
  endtask

  initial begin
    int rises0, ack_pct;
    rst = 1'b1;
    bif.if_req_i = 0; bif.if_addr_i = 0;
    bif.mem_req_i = 0; bif.mem_we_i = 0; bif.mem_sel_i = 0;
    bif.mem_addr_i = 0; bif.mem_wdata_i = 0;
    bif.bus_rdata_i = 0; bif.bus_ack_i = 0;

    // reset state
    tick("reset"); tick("reset");
    chk("reset.stb_const", bif.bus_stb_o, 0);
    chk("reset.rdata_const", bif.if_rdata_o, 0);
    rst = 1'b0;
    tick("idle");

    // fetch, slave acks one cycle after stb
    bif.if_req_i = 1; bif.if_addr_i = 32'h0000_0100;
    tick("fetch.grant");
    chk("fetch.addr_const", bif.bus_addr_o, 32'h100);
    chk("fetch.we_const", bif.bus_we_o, 0);
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h2408_0001;
    tick("fetch.ack");
    chk("fetch.ack_const", bif.if_ack_o, 1);
    chk("fetch.rdata_const", bif.if_rdata_o, 32'h2408_0001);
    bif.bus_ack_i = 0; bif.if_req_i = 0;
    tick("fetch.done");
    chk("fetch.ack_pulse", bif.if_ack_o, 0);

    // store, ack after 3 stb cycles; requester inputs wiggle meanwhile
    bif.mem_req_i = 1; bif.mem_we_i = 1; bif.mem_sel_i = 4'b0011;
    bif.mem_addr_i = 32'h8000_0004; bif.mem_wdata_i = 32'h1234_5678;
    tick("store.grant");
    bif.mem_addr_i = 32'hFFFF_0000; bif.mem_wdata_i = 32'h0BAD_0BAD; bif.mem_sel_i = 4'hC;
    tick("store.wait1");
    tick("store.wait2");
    chk("store.addr_hold", bif.bus_addr_o, 32'h8000_0004);
    chk("store.wdata_hold", bif.bus_wdata_o, 32'h1234_5678);
    chk("store.sel_hold", bif.bus_sel_o, 4'b0011);
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'hDEAD_BEEF;
    tick("store.ack");
    chk("store.rdata_zero", bif.mem_rdata_o, 0);
    bif.bus_ack_i = 0; bif.mem_req_i = 0; bif.mem_we_i = 0;
    tick("store.done");

    // collision: MEM first, IF right after
    bif.if_req_i = 1; bif.if_addr_i = 32'h200;
    bif.mem_req_i = 1; bif.mem_sel_i = 4'hF; bif.mem_addr_i = 32'h300;
    tick("coll.grant");
    chk("coll.mem_first", bif.bus_addr_o, 32'h300);
    tick("coll.wait");
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'hAAAA_5555;
    tick("coll.mem_ack");
    chk("coll.no_if_ack", bif.if_ack_o, 0);
    bif.bus_ack_i = 0; bif.mem_req_i = 0;
    tick("coll.if_grant");
    chk("coll.if_addr", bif.bus_addr_o, 32'h200);
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h1111_2222;
    tick("coll.if_ack");
    bif.bus_ack_i = 0; bif.if_req_i = 0;
    tick("coll.done");

    // back-to-back: req held through ack cycle (masked), then reissued
    rises0 = stb_rises;
    bif.mem_req_i = 1; bif.mem_addr_i = 32'h400;
    tick("b2b.grant1");
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h4444_0000;
    tick("b2b.ack1");
    bif.bus_ack_i = 0;
    tick("b2b.masked");
    chk("b2b.masked_stb", bif.bus_stb_o, 0);
    tick("b2b.grant2");
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h4444_0001;
    tick("b2b.ack2");
    bif.bus_ack_i = 0; bif.mem_req_i = 0;
    tick("b2b.done");
    chk("b2b.stb_count", stb_rises - rises0, 2);

    // ack while idle is ignored
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h5555_5555;
    tick("idle_ack"); tick("idle_ack");
    chk("idle_ack.none", {bif.if_ack_o, bif.mem_ack_o}, 0);
    bif.bus_ack_i = 0;

    // timeout on a load that never gets acked
    bif.mem_req_i = 1; bif.mem_addr_i = 32'h500;
    tick("tmo.grant");
    for (int i = 1; i < TIMEOUT; i++) tick("tmo.wait");
    chk("tmo.stb_still", bif.bus_stb_o, 1);
    tick("tmo.abort");
    chk("tmo.stb_drop", bif.bus_stb_o, 0);
    chk("tmo.err", bif.bus_err_o, 1);
    chk("tmo.ack", bif.mem_ack_o, 1);
    chk("tmo.rdata", bif.mem_rdata_o, 0);
    bif.mem_req_i = 0;
    tick("tmo.done");

    // reset mid-fetch, late ack ignored
    bif.if_req_i = 1; bif.if_addr_i = 32'h600;
    tick("rstmid.grant");
    rst = 1; bif.if_req_i = 0;
    tick("rstmid.reset");
    rst = 0; bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h6666_6666;
    tick("rstmid.late_ack");
    chk("rstmid.no_ack", bif.if_ack_o, 0);
    chk("rstmid.stb", bif.bus_stb_o, 0);
    chk("rstmid.addr", bif.bus_addr_o, 0);
    bif.bus_ack_i = 0;

    // randomized traffic
    ack_pct = 30;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 100 == 0) ack_pct = $urandom_range(3, 60);
      rst = ($urandom % 250 == 0);
      if (!bif.if_req_i || m_if_ack) begin
        if (bif.if_req_i && m_if_ack && ($urandom % 4 == 0)) begin
          // keep req high: same fetch reissued after the masked cycle
        end else begin
          bif.if_req_i = ($urandom % 3 == 0);
          bif.if_addr_i = $urandom & 32'hFFFF_FFFC;
        end
      end
      if (!bif.mem_req_i || m_mem_ack) begin
        if (bif.mem_req_i && m_mem_ack && ($urandom % 4 == 0)) begin
        end else begin
          bif.mem_req_i = ($urandom % 3 == 0);
          bif.mem_we_i = $urandom;
          bif.mem_sel_i = $urandom;
          bif.mem_addr_i = $urandom;
          bif.mem_wdata_i = $urandom;
        end
      end
      bif.bus_rdata_i = $urandom;
      bif.bus_ack_i = m_stb ? ($urandom_range(0, 99) < ack_pct) : ($urandom % 8 == 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1);
  end
endmodule
